// File: rtl/instruction_cache_responder.sv
// Direct-mapped read-only instruction cache answering fetch requests; fills a block from memory on a miss.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module instruction_cache_responder #(
  parameter int          NUM_SETS    = 8,
  parameter int          BLOCK_WORDS = 4,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFFFFFC,
  localparam int OFF_W = $clog2(BLOCK_WORDS),
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int BLK_W = 32 - OFF_W - 2,
  localparam int TAG_W = BLK_W - IDX_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               address,
  output logic [31:0]               instruction,
  output logic                      busywait,
  output logic                      mem_read,
  output logic [BLK_W-1:0]          mem_address,
  input  logic [32*BLOCK_WORDS-1:0] mem_readdata,
  input  logic                      mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

  state_e                                 state_q, state_d;
  logic [BLK_W-1:0]                       blk_addr_q, blk_addr_d;
  logic [NUM_SETS-1:0]                    valid_q, valid_d;
  logic [NUM_SETS-1:0][TAG_W-1:0]         tag_q, tag_d;
  logic [NUM_SETS-1:0][BLOCK_WORDS-1:0][31:0] data_q, data_d;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             req_active, hit;
  logic             unused_addr_bits;

  assign req_off    = address[OFF_W+1:2];
  assign req_idx    = address[OFF_W+2 +: IDX_W];
  assign req_tag    = address[31 -: TAG_W];
  assign req_active = (address != IDLE_ADDR);
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^address[1:0];

  // The fill targets the block latched on the miss, not the live address.
  assign fill_idx = blk_addr_q[IDX_W-1:0];
  assign fill_tag = blk_addr_q[BLK_W-1 -: TAG_W];

  always_comb begin
    state_d     = state_q;
    blk_addr_d  = blk_addr_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    instruction = 32'h0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_q)
      IDLE: begin
        if (req_active) begin
          if (hit) begin
            instruction = data_q[req_idx][req_off];
          end else begin
            busywait   = 1'b1;
            blk_addr_d = {req_tag, req_idx};
            state_d    = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = blk_addr_q;
        if (!mem_busywait) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = fill_tag;
          data_d[fill_idx]  = mem_readdata;
          state_d           = UPDATE;
        end
      end
      UPDATE: begin
        busywait = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      blk_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      blk_addr_q <= blk_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data storage is qualified by valid, so it carries no reset.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req_active) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache_responder.sv
// Scoreboard bench for instruction_cache_responder: the driver queues expected words, a negedge monitor checks them.
module tb_instruction_cache_responder;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFFFFFC;
  localparam int MEM_LAT = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  instruction_cache_responder dut (
    .clock(clock), .reset(reset), .address(address), .instruction(instruction),
    .busywait(busywait), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [27:0] exp_blk = '0;
  int          mem_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: busy for MEM_LAT sampled cycles of a request, then presents block words blk*16 + w*0x11.
  always @(negedge clock) begin
    if (mem_read) begin
      if (mem_cnt < MEM_LAT) begin
        mem_busywait = 1'b1;
        mem_cnt++;
      end else begin
        mem_busywait = 1'b0;
        for (int w = 0; w < 4; w++)
          mem_readdata[w*32 +: 32] = ({4'h0, mem_address} << 4) + w * 32'h11;
        chk("mem_address", {4'h0, mem_address}, {4'h0, exp_blk});
      end
    end else begin
      mem_cnt      = 0;
      mem_busywait = 1'b1;
    end
  end

  // Monitor: every cycle the DUT presents a word for a real fetch, compare against the queue head.
  always @(negedge clock) begin
    if (!reset && !busywait && address != IDLE_ADDR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", instruction);
      end else begin
        chk("instruction", instruction, exp_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                       input int exp_bw, input logic [27:0] blk);
    int bw = 0;
    bit saw_mr = 1'b0;
    exp_blk = blk;
    exp_q.push_back(exp_instr);
    address = a;
    @(negedge clock);
    while (busywait && bw < 50) begin
      bw++;
      if (mem_read) saw_mr = 1'b1;
      @(negedge clock);
    end
    if (mem_read) saw_mr = 1'b1;
    chk("busy_cycles", bw, exp_bw);
    if (exp_bw == 0) chk("mem_read_on_hit", {31'h0, saw_mr}, 32'h0);
    @(posedge clock); #1;
    address = IDLE_ADDR;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset        = 1'b1;
    address      = IDLE_ADDR;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    #3;
    chk("rst_busywait", {31'h0, busywait}, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_address", {4'h0, mem_address}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle_busywait", {31'h0, busywait}, 32'h0);
      chk("idle_mem_read", {31'h0, mem_read}, 32'h0);
      chk("idle_instruction", instruction, 32'h0);
    end
    @(posedge clock); #1;

    // Cold miss then hits in the same block.
    fetch(32'h0000_0000, 32'h0000_0000, 6, 28'h0);
    fetch(32'h0000_0004, 32'h0000_0011, 0, 28'h0);
    fetch(32'h0000_0008, 32'h0000_0022, 0, 28'h0);
    fetch(32'h0000_000C, 32'h0000_0033, 0, 28'h0);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd4);
    chk("miss_count", miss_count, 32'd1);
`endif

    // Conflict on index 0: 0x80 evicts 0x00, which then misses again.
    fetch(32'h0000_0080, 32'h0000_0080, 6, 28'h8);
    fetch(32'h0000_0084, 32'h0000_0091, 0, 28'h8);
    fetch(32'h0000_0000, 32'h0000_0000, 6, 28'h0);

    // Reset in the second MEM_READ cycle of a fill for 0x100.
    exp_blk = 28'h10;
    address = 32'h0000_0100;
    n = 0;
    @(negedge clock);
    while (!mem_read && n < 10) begin
      n++;
      @(negedge clock);
    end
    chk("fill_started", {31'h0, mem_read}, 32'h1);
    @(posedge clock); #1;
    chk("mid_fill_mem_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_mem_read_drop", {31'h0, mem_read}, 32'h0);
    chk("async_mem_address", {4'h0, mem_address}, 32'h0);
    address = IDLE_ADDR;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    fetch(32'h0000_0000, 32'h0000_0000, 6, 28'h0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_cache_responder.md
Name: instruction_cache_responder

Overview:
- Responder side of the fetch-to-instruction-memory interface.
- Accepts the fetch address (PC) from the instruction fetch stage and returns a 32-bit instruction word.
- Asserts busywait while the word is unavailable.
- Direct-mapped, read-only cache; on a miss it fills one block from instruction memory over a request/busywait handshake.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, ≥2.
- BLOCK_WORDS, 4, 32-bit words per line; power of two, ≥2.
- IDLE_ADDR, 32'hFFFFFFFC, fetch address meaning "no request" (post-reset PC value).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- address  input  32  byte fetch address from fetch stage; bits [1:0] ignored.
- instruction  output  32  instruction word; valid when busywait=0.
- busywait  output  1  high while the requested word is unavailable; fetch stage must hold address.
- mem_read  output  1  block read request to instruction memory.
- mem_address  output  32-log2(BLOCK_WORDS)-2  block address {tag,index}.
- mem_readdata  input  32*BLOCK_WORDS  fill block; word 0 in LSBs.
- mem_busywait  input  1  memory busy; data valid on the first posedge with mem_read=1 and mem_busywait=0.

Behaviour:
- Address split: word offset = [log2(BLOCK_WORDS)+1:2]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, data block. Reset clears all valid bits (asynchronous).
- hit = valid[index] && tag match.
- State IDLE, address != IDLE_ADDR, hit:
  - instruction = selected word, combinational.
  - busywait = 0; zero-cycle latency.
- State IDLE, address != IDLE_ADDR, miss:
  - busywait = 1, combinational in the same cycle.
  - Next posedge → MEM_READ.
- State IDLE, address == IDLE_ADDR: busywait=0, instruction=32'h0, no state change.
- MEM_READ:
  - mem_read=1; mem_address={tag,index} of the current address; busywait=1.
  - Stays while mem_busywait=1.
  - On posedge with mem_busywait=0: latch mem_readdata into line[index], set tag, set valid → UPDATE.
- UPDATE: mem_read=0, busywait=1. Next posedge → IDLE, where the access now hits and busywait drops combinationally.
- Miss cost: busywait high for 2+W cycles, where W = cycles spent in MEM_READ.
- Address must be stable while busywait=1. Address change during MEM_READ is illegal; it is not checked and the fill uses the latched block address.
- Eviction: a miss overwrites the line unconditionally. There is no dirty state and no write path.
- Reset at any time, including mid-fill:
  - State → IDLE; mem_read=0 immediately.
  - All valid bits cleared.
  - A partial fill is discarded; late mem_readdata is ignored.
- Reset values: instruction=0, busywait=0 (given address==IDLE_ADDR), mem_read=0, mem_address=0.
- No X on outputs after reset. Data arrays need not be reset.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Extra outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each posedge in IDLE with a hit, address != IDLE_ADDR, and busywait=0 (one count per accepted fetch cycle).
  - miss_count increments on each IDLE→MEM_READ transition.
  - Both counters wrap at 2^32, reset to 0, and are cleared by reset.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, address=0xFFFFFFFC → busywait=0, instruction=0, mem_read=0; no state change over 5 cycles.
- Cold miss at address 0x00000000, memory busy 3 cycles, block {0x33,0x22,0x11,0x00}:
  - mem_read=1 with mem_address=0 during MEM_READ.
  - busywait high 2+4=6 cycles, then instruction=0x00.
- Following fetches 0x4, 0x8, 0xC → hits, busywait=0 each cycle, instructions 0x11, 0x22, 0x33, mem_read never asserted.
- Conflict: fill 0x00, then fetch 0x80 (same index, different tag) → miss and refill; then 0x00 → miss again (line evicted).
- Reset asserted during the 2nd MEM_READ cycle:
  - mem_read drops asynchronously.
  - After release, fetch 0x00 → miss again (valid cleared).
- With ICACHE_STATS_EN: scenario 2 then 3 → miss_count=1, hit_count=4.
